// File: rtl/if_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared pipeline defines for the instruction fetch stage: FSM state
// encodings, the default reset PC, the bubble word driven into IF/ID when no
// instruction is presented, and the output-buffer entry layout.
// -----------------------------------------------------------------------------
package if_fetch_unit_pkg;

  // Fetch FSM states.
  //   S_REQ  : free to issue a read at pc_q
  //   S_WAIT : one read outstanding, its data will be kept
  //   S_DROP : one read outstanding, but a redirect made it stale
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Bubble encoding shared with the IF/ID flush path.
  localparam logic [31:0] BUBBLE_WORD = 32'd0;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_add4;
  } fetch_entry_t;

  localparam fetch_entry_t BUBBLE_ENTRY = '{
    valid:   1'b0,
    pc:      BUBBLE_WORD,
    instr:   BUBBLE_WORD,
    pc_add4: BUBBLE_WORD
  };

  // Instructions are word aligned; low address bits of a target are ignored.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// One-entry output buffer holding the instruction presented to IF/ID.
//   clk_i, rst_i      : clock, asynchronous active-low reset
//   flush_i           : drop the entry (redirect), highest priority
//   load_i            : capture a returning instruction
//   load_pc_i/...     : fields of the instruction being captured
//   stall_i           : decode hold; while high a valid entry is kept
//   valid_o, pc_o,
//   instr_o, pc_add4_o: presented triple, all-zero when not valid
// -----------------------------------------------------------------------------
module fetch_buffer
  import if_fetch_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic [31:0] load_instr_i,
  input  logic [31:0] load_pc_add4_i,
  input  logic        stall_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_add4_o
);

  fetch_entry_t buf_q, buf_d;

  // A load wins over consumption so a fetch issued in the consuming cycle can
  // refill the entry. An empty entry is always stored as the bubble word, so
  // the outputs need no extra gating.
  always_comb begin
    buf_d = buf_q;
    if (flush_i) begin
      buf_d = BUBBLE_ENTRY;
    end else if (load_i) begin
      buf_d.valid   = 1'b1;
      buf_d.pc      = load_pc_i;
      buf_d.instr   = load_instr_i;
      buf_d.pc_add4 = load_pc_add4_i;
    end else if (buf_q.valid && !stall_i) begin
      buf_d = BUBBLE_ENTRY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) buf_q <= BUBBLE_ENTRY;
    else        buf_q <= buf_d;
  end

  assign valid_o   = buf_q.valid;
  assign pc_o      = buf_q.pc;
  assign instr_o   = buf_q.instr;
  assign pc_add4_o = buf_q.pc_add4;

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage: walks pc_q through instruction memory with at most
// one read in flight and presents each returned instruction to IF/ID through
// a one-entry buffer.
//   clk_i, rst_i          : clock, asynchronous active-low reset
//   stall_i               : decode hold (ID_redo)
//   redirect_i,
//   redirect_pc_i         : branch/jump flush and its new target
//   imem_req_o,
//   imem_addr_o           : single-cycle read request, address = pc_q
//   imem_rvalid_i,
//   imem_rdata_i          : read response, one or more cycles after request
//   pc_o, instr_o,
//   pc_add4_o, valid_o    : presented instruction triple for IF/ID
// -----------------------------------------------------------------------------
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_add4_o,
  output logic        valid_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_add4;
  logic         buf_load;

  assign pc_add4 = pc_q + INSTR_BYTES;  // wraps 32'hFFFF_FFFC -> 0

  // Issue only when the returning word will have somewhere to go: the buffer
  // is empty or is being consumed this cycle. rst_i gates the request so the
  // memory sees nothing while reset is held, yet the first request goes out
  // in the same cycle reset is released.
  assign imem_req_o  = rst_i && (state_q == S_REQ) && (!valid_o || !stall_i)
                       && !redirect_i;
  assign imem_addr_o = pc_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_load = 1'b0;

    if (redirect_i) begin
      pc_d = align_pc(redirect_pc_i);
      unique case (state_q)
        S_REQ:  state_d = S_REQ;
        // A read is still in flight: if it lands this very cycle it is simply
        // discarded, otherwise remember to drop it when it arrives.
        S_WAIT: state_d = imem_rvalid_i ? S_REQ : S_DROP;
        // The stale read is still owed; a response landing together with the
        // redirect settles it, otherwise keep waiting for it.
        S_DROP: state_d = imem_rvalid_i ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_req_o) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            buf_load = 1'b1;
            pc_d     = pc_add4;
            state_d  = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid_i) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (redirect_i),
    .load_i         (buf_load),
    .load_pc_i      (pc_q),
    .load_instr_i   (imem_rdata_i),
    .load_pc_add4_i (pc_add4),
    .stall_i        (stall_i),
    .valid_o        (valid_o),
    .pc_o           (pc_o),
    .instr_o        (instr_o),
    .pc_add4_o      (pc_add4_o)
  );

endmodule
